// File: rtl/stream_byte_swapper.sv
// stream_byte_swapper
//
// Streaming byte-order reversal stage for a valid/ready datapath. Each beat
// is split into groups of 2**in_size_log2 bytes and the byte order inside
// every group is reversed (output byte i = input byte i XOR (G-1)). Byte
// enables follow the same permutation. A group size larger than the bus is
// flagged on out_err, the beat passes through unchanged, and a saturating
// counter records how many such beats were accepted.
//
// The permutation is combinational on the input side. Storage is one output
// register plus one skid register, so the stage runs at one beat per cycle
// and in_ready is a plain register with no path from out_ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_data           8*DATA_BYTES bits, byte 0 in [7:0]
//   in_keep           byte enables, bit i qualifies byte i
//   in_last           end of packet, passed through
//   in_size_log2      log2 of the swap group size in bytes
//   out_valid/out_ready output handshake
//   out_data/out_keep permuted data and enables
//   out_last          delayed in_last
//   out_err           beat carried an illegal in_size_log2
//   err_count         saturating count of accepted illegal beats
module stream_byte_swapper #(
    parameter int DATA_BYTES = 8,
    parameter int SW         = $clog2(DATA_BYTES) + 1,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    input  logic [SW-1:0]           in_size_log2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic [DATA_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    out_err,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam int LG = $clog2(DATA_BYTES);
    localparam int DW = 8 * DATA_BYTES;

    // ------------------------------------------------------------------
    // Combinational permutation of the incoming beat
    // ------------------------------------------------------------------
    logic          size_ok;
    logic [LG-1:0] swp_mask;
    logic [LG-1:0] src;
    logic [DW-1:0] sw_data;
    logic [DATA_BYTES-1:0] sw_keep;

    assign size_ok = (in_size_log2 <= SW'(LG));

    // XOR mask is G-1; an illegal size forces identity mapping.
    always_comb begin
        swp_mask = '0;
        if (size_ok) begin
            swp_mask = LG'((32'd1 << in_size_log2) - 32'd1);
        end
    end

    always_comb begin
        sw_data = '0;
        sw_keep = '0;
        src     = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            src                 = LG'(i) ^ swp_mask;
            sw_data[8*i +: 8]   = in_data[{src, 3'b000} +: 8];
            sw_keep[i]          = in_keep[src];
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid register
    // ------------------------------------------------------------------
    logic                  out_valid_q, out_valid_d;
    logic [DW-1:0]         out_data_q,  out_data_d;
    logic [DATA_BYTES-1:0] out_keep_q,  out_keep_d;
    logic                  out_last_q,  out_last_d;
    logic                  out_err_q,   out_err_d;

    logic                  skid_valid_q, skid_valid_d;
    logic [DW-1:0]         skid_data_q,  skid_data_d;
    logic [DATA_BYTES-1:0] skid_keep_q,  skid_keep_d;
    logic                  skid_last_q,  skid_last_d;
    logic                  skid_err_q,   skid_err_d;

    logic                  in_ready_q,   in_ready_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q,    err_cnt_d;

    logic acc;
    logic out_load;

    // in_ready_q always mirrors !skid_valid_q, so an accepted beat can never
    // coincide with the skid draining; the skid is either the load source or
    // the input is, never both.
    assign acc      = in_valid && in_ready_q;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        skid_err_d   = skid_err_q;
        err_cnt_d    = err_cnt_q;

        if (out_load) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d  = 1'b1;
                out_data_d   = sw_data;
                out_keep_d   = sw_keep;
                out_last_d   = in_last;
                out_err_d    = !size_ok;
            end else begin
                // Payload is left as-is; only the valid flag drops.
                out_valid_d  = 1'b0;
            end
        end else if (acc) begin
            // Output stalled and occupied: park the beat in the skid.
            skid_valid_d = 1'b1;
            skid_data_d  = sw_data;
            skid_keep_d  = sw_keep;
            skid_last_d  = in_last;
            skid_err_d   = !size_ok;
        end

        if (acc && !size_ok && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // The register already holds 1 during reset so ready is up in the very
    // first cycle after release; the rst term only masks it while in reset.
    assign in_ready  = in_ready_q && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_stream_byte_swapper.sv
// Self-checking bench for stream_byte_swapper: directed tests on an 8-byte
// instance (plus a twin with a 2-bit error counter sharing its inputs) and a
// lockstep random sweep over 2-, 16- and 64-byte instances.
module tb_stream_byte_swapper;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    // 8-byte group
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [7:0]  a_in_keep, a_out_keep;
    logic [3:0]  a_size;
    logic        a_out_last, a_out_err;
    logic [15:0] a_err_count;
    logic        e_in_ready, e_out_valid, e_out_last, e_out_err;
    logic [63:0] e_out_data;
    logic [7:0]  e_out_keep;
    logic [1:0]  e_err_count;

    // width sweep group (shared inputs)
    logic         w_in_valid, w_out_ready, w_last;
    logic [511:0] w_data;
    logic [63:0]  w_keep;
    logic [6:0]   w_size;
    logic         w2_in_ready, w2_out_valid, w2_out_last, w2_out_err;
    logic [15:0]  w2_out_data;
    logic [1:0]   w2_out_keep;
    logic [15:0]  w2_err;
    logic         w16_in_ready, w16_out_valid, w16_out_last, w16_out_err;
    logic [127:0] w16_out_data;
    logic [15:0]  w16_out_keep;
    logic [15:0]  w16_err;
    logic         w64_in_ready, w64_out_valid, w64_out_last, w64_out_err;
    logic [511:0] w64_out_data;
    logic [63:0]  w64_out_keep;
    logic [15:0]  w64_err;

    stream_byte_swapper #(.DATA_BYTES(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_keep(a_in_keep), .in_last(a_in_last), .in_size_log2(a_size),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_keep(a_out_keep), .out_last(a_out_last), .out_err(a_out_err), .err_count(a_err_count));

    stream_byte_swapper #(.DATA_BYTES(8), .ERR_CNT_W(2)) u8e (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(e_in_ready),
        .in_data(a_in_data), .in_keep(a_in_keep), .in_last(a_in_last), .in_size_log2(a_size),
        .out_valid(e_out_valid), .out_ready(a_out_ready), .out_data(e_out_data),
        .out_keep(e_out_keep), .out_last(e_out_last), .out_err(e_out_err), .err_count(e_err_count));

    stream_byte_swapper #(.DATA_BYTES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w2_in_ready),
        .in_data(w_data[15:0]), .in_keep(w_keep[1:0]), .in_last(w_last), .in_size_log2(w_size[1:0]),
        .out_valid(w2_out_valid), .out_ready(w_out_ready), .out_data(w2_out_data),
        .out_keep(w2_out_keep), .out_last(w2_out_last), .out_err(w2_out_err), .err_count(w2_err));

    stream_byte_swapper #(.DATA_BYTES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w16_in_ready),
        .in_data(w_data[127:0]), .in_keep(w_keep[15:0]), .in_last(w_last), .in_size_log2(w_size[4:0]),
        .out_valid(w16_out_valid), .out_ready(w_out_ready), .out_data(w16_out_data),
        .out_keep(w16_out_keep), .out_last(w16_out_last), .out_err(w16_out_err), .err_count(w16_err));

    stream_byte_swapper #(.DATA_BYTES(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w64_in_ready),
        .in_data(w_data), .in_keep(w_keep), .in_last(w_last), .in_size_log2(w_size),
        .out_valid(w64_out_valid), .out_ready(w_out_ready), .out_data(w64_out_data),
        .out_keep(w64_out_keep), .out_last(w64_out_last), .out_err(w64_out_err), .err_count(w64_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int lg2(input int nb);
        int r;
        r = 0;
        while ((1 << r) < nb) r++;
        return r;
    endfunction

    function automatic logic m_err(input int s, input int nb);
        return (s & (2*nb - 1)) > lg2(nb);
    endfunction

    function automatic logic [511:0] m_data(input logic [511:0] d, input int s, input int nb);
        logic [511:0] r;
        int se;
        se = s & (2*nb - 1);
        r  = '0;
        for (int i = 0; i < nb; i++)
            r[8*i +: 8] = m_err(s, nb) ? d[8*i +: 8] : d[8*(i ^ ((1 << se) - 1)) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_keep(input logic [63:0] k, input int s, input int nb);
        logic [63:0] r;
        int se;
        se = s & (2*nb - 1);
        r  = '0;
        for (int i = 0; i < nb; i++)
            r[i] = m_err(s, nb) ? k[i] : k[i ^ ((1 << se) - 1)];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_tests++; if ({a_out_data, a_out_keep, a_out_last, a_out_err} !== 74'd0) begin n_fail++; $display("FAIL reset_payload: got %h/%h/%b/%b want 0", a_out_data, a_out_keep, a_out_last, a_out_err); end
        n_tests++; if (a_err_count !== 16'd0 || e_err_count !== 2'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d/%0d want 0", a_err_count, e_err_count); end
        rst = 1'b0;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", a_out_valid); end
        tick();
    endtask

    task automatic test_size_sweep;
        logic [63:0] exp_d [4];
        logic [7:0]  exp_k [4];
        exp_d[0] = 64'h0011223344556677; exp_k[0] = 8'h0F;
        exp_d[1] = 64'h1100332255447766; exp_k[1] = 8'h0F;
        exp_d[2] = 64'h3322110077665544; exp_k[2] = 8'h0F;
        exp_d[3] = 64'h7766554433221100; exp_k[3] = 8'hF0;
        a_out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_in_valid = 1'b1; a_in_data = 64'h0011223344556677; a_in_keep = 8'h0F;
            a_in_last = (s % 2 == 1); a_size = 4'(s);
            n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL size_ready s=%0d: got %b want 1", s, a_in_ready); end
            tick();
            a_in_valid = 1'b0;
            n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL size_valid s=%0d: got %b want 1", s, a_out_valid); end
            n_tests++; if (a_out_data !== exp_d[s]) begin n_fail++; $display("FAIL size_data s=%0d: got %h want %h", s, a_out_data, exp_d[s]); end
            n_tests++; if (a_out_keep !== exp_k[s]) begin n_fail++; $display("FAIL size_keep s=%0d: got %h want %h", s, a_out_keep, exp_k[s]); end
            n_tests++; if (a_out_last !== (s % 2 == 1) || a_out_err !== 1'b0) begin n_fail++; $display("FAIL size_last_err s=%0d: got %b/%b want %b/0", s, a_out_last, a_out_err, (s % 2 == 1)); end
            tick();
        end
    endtask

    task automatic test_stream;
        logic [63:0]  d  [64];
        logic [7:0]   k  [64];
        logic         l  [64];
        int           sz [64];
        logic [511:0] ed;
        logic [63:0]  ek;
        for (int i = 0; i < 64; i++) begin
            d[i] = {$urandom, $urandom}; k[i] = 8'($urandom);
            l[i] = 1'($urandom_range(0, 1)); sz[i] = $urandom_range(0, 3);
        end
        a_out_ready = 1'b1;
        for (int c = 0; c <= 64; c++) begin
            if (c < 64) begin
                a_in_valid = 1'b1; a_in_data = d[c]; a_in_keep = k[c]; a_in_last = l[c]; a_size = 4'(sz[c]);
                n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b want 1", c, a_in_ready); end
            end else begin
                a_in_valid = 1'b0;
            end
            if (c > 0) begin
                ed = m_data({448'd0, d[c-1]}, sz[c-1], 8);
                ek = m_keep({56'd0, k[c-1]}, sz[c-1], 8);
                n_tests++;
                if (a_out_valid !== 1'b1 || a_out_data !== ed[63:0] || a_out_keep !== ek[7:0] || a_out_last !== l[c-1]) begin
                    n_fail++;
                    $display("FAIL stream_beat %0d: got v=%b %h/%h/%b want v=1 %h/%h/%b", c-1, a_out_valid, a_out_data, a_out_keep, a_out_last, ed[63:0], ek[7:0], l[c-1]);
                end
            end
            tick();
        end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", a_out_valid); end
    endtask

    task automatic test_backpressure;
        a_out_ready = 1'b1; a_size = 4'd0; a_in_keep = 8'hFF; a_in_last = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'hB0B0B0B0_00000000;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c0: got %b want 1", a_in_ready); end
        tick();
        a_out_ready = 1'b0; a_in_data = 64'hB1B1B1B1_00000001;
        n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== 64'hB0B0B0B0_00000000) begin
            n_fail++; $display("FAIL bp_stall1: got r=%b v=%b %h want r=1 v=1 b0b0b0b000000000", a_in_ready, a_out_valid, a_out_data); end
        tick();
        a_in_data = 64'hB2B2B2B2_00000002;
        for (int st = 2; st <= 5; st++) begin
            n_tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 64'hB0B0B0B0_00000000) begin
                n_fail++; $display("FAIL bp_stall%0d: got r=%b v=%b %h want r=0 v=1 b0b0b0b000000000", st, a_in_ready, a_out_valid, a_out_data); end
            tick();
        end
        a_out_ready = 1'b1;
        n_tests++; if (a_in_ready !== 1'b0 || a_out_data !== 64'hB0B0B0B0_00000000) begin
            n_fail++; $display("FAIL bp_release: got r=%b %h want r=0 b0b0b0b000000000", a_in_ready, a_out_data); end
        tick();
        n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== 64'hB1B1B1B1_00000001) begin
            n_fail++; $display("FAIL bp_skid_out: got r=%b v=%b %h want r=1 v=1 b1b1b1b100000001", a_in_ready, a_out_valid, a_out_data); end
        tick();
        a_in_valid = 1'b0;
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'hB2B2B2B2_00000002) begin
            n_fail++; $display("FAIL bp_third: got v=%b %h want v=1 b2b2b2b200000002", a_out_valid, a_out_data); end
        tick();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", a_out_valid); end
    endtask

    task automatic test_illegal;
        int          szs [5];
        logic [63:0] dv;
        szs[0] = 4; szs[1] = 7; szs[2] = 4; szs[3] = 5; szs[4] = 6;
        a_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            dv = 64'h0011223344556677 ^ 64'(j);
            a_in_valid = 1'b1; a_in_data = dv; a_in_keep = 8'h0F; a_in_last = 1'b1; a_size = 4'(szs[j]);
            n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready j=%0d: got %b want 1", j, a_in_ready); end
            tick();
            a_in_valid = 1'b0;
            n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== dv || a_out_keep !== 8'h0F || a_out_err !== 1'b1) begin
                n_fail++; $display("FAIL ill_beat j=%0d: got v=%b %h/%h err=%b want v=1 %h/0f err=1", j, a_out_valid, a_out_data, a_out_keep, a_out_err, dv); end
            n_tests++; if (a_err_count !== 16'(j + 1)) begin n_fail++; $display("FAIL ill_count j=%0d: got %0d want %0d", j, a_err_count, j + 1); end
            n_tests++; if (e_err_count !== 2'((j + 1 > 3) ? 3 : j + 1)) begin n_fail++; $display("FAIL ill_sat j=%0d: got %0d want %0d", j, e_err_count, (j + 1 > 3) ? 3 : j + 1); end
            n_tests++; if ({e_in_ready, e_out_valid, e_out_data, e_out_keep, e_out_last, e_out_err} !== {a_in_ready, a_out_valid, a_out_data, a_out_keep, a_out_last, a_out_err}) begin
                n_fail++; $display("FAIL ill_twin j=%0d: got %h want %h", j, e_out_data, a_out_data); end
            tick();
        end
        a_in_valid = 1'b1; a_in_data = 64'h0011223344556677; a_size = 4'd1;
        tick();
        a_in_valid = 1'b0;
        n_tests++; if (a_out_err !== 1'b0 || a_out_data !== 64'h1100332255447766 || a_err_count !== 16'd5) begin
            n_fail++; $display("FAIL ill_legal_after: got err=%b %h cnt=%0d want err=0 1100332255447766 cnt=5", a_out_err, a_out_data, a_err_count); end
        tick();
    endtask

    task automatic test_reset_mid;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_size = 4'd3; a_in_keep = 8'hFF;
        a_in_data = 64'hDEAD0000_00000001;
        tick();
        a_in_data = 64'hDEAD0000_00000002;
        tick();
        n_tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got r=%b v=%b want r=0 v=1", a_in_ready, a_out_valid); end
        rst = 1'b1;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b want 0", a_in_ready); end
        tick();
        n_tests++; if (a_out_valid !== 1'b0 || a_err_count !== 16'd0 || a_in_ready !== 1'b0 || a_out_data !== 64'd0) begin
            n_fail++; $display("FAIL rmid_after_edge: got v=%b cnt=%0d r=%b %h want v=0 cnt=0 r=0 0", a_out_valid, a_err_count, a_in_ready, a_out_data); end
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        #1;
        n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_release: got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale c=%0d: got %b want 0", c, a_out_valid); end
        end
    endtask

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        int           s;
    } beat_t;

    task automatic test_width_sweep;
        beat_t        q[$];
        beat_t        b;
        int           ec2, ec16, ec64;
        logic [511:0] ed;
        logic [63:0]  ek;
        ec2 = 0; ec16 = 0; ec64 = 0;
        for (int cyc = 0; cyc < 340; cyc++) begin
            if (cyc < 300) begin
                w_in_valid  = ($urandom_range(0, 9) < 7);
                w_out_ready = ($urandom_range(0, 9) < 6);
                for (int i = 0; i < 16; i++) w_data[32*i +: 32] = $urandom;
                w_keep = {$urandom, $urandom};
                w_last = 1'($urandom_range(0, 1));
                w_size = 7'($urandom_range(0, 7));
            end else begin
                w_in_valid  = 1'b0;
                w_out_ready = 1'b1;
            end
            n_tests++; if (w16_in_ready !== w2_in_ready || w64_in_ready !== w2_in_ready || w16_out_valid !== w2_out_valid || w64_out_valid !== w2_out_valid) begin
                n_fail++; $display("FAIL ws_lockstep cyc=%0d: got r=%b%b%b v=%b%b%b want equal", cyc, w2_in_ready, w16_in_ready, w64_in_ready, w2_out_valid, w16_out_valid, w64_out_valid); end
            if (w2_out_valid === 1'b1 && w_out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL ws_extra_beat cyc=%0d: got output want none", cyc);
                end else begin
                    b = q.pop_front();
                    ed = m_data(b.d, b.s, 2); ek = m_keep(b.k, b.s, 2);
                    if (w2_out_data !== ed[15:0] || w2_out_keep !== ek[1:0] || w2_out_last !== b.l || w2_out_err !== m_err(b.s, 2)) begin
                        n_fail++; $display("FAIL ws_w2 cyc=%0d s=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", cyc, b.s, w2_out_data, w2_out_keep, w2_out_last, w2_out_err, ed[15:0], ek[1:0], b.l, m_err(b.s, 2)); end
                    n_tests++;
                    ed = m_data(b.d, b.s, 16); ek = m_keep(b.k, b.s, 16);
                    if (w16_out_data !== ed[127:0] || w16_out_keep !== ek[15:0] || w16_out_last !== b.l || w16_out_err !== m_err(b.s, 16)) begin
                        n_fail++; $display("FAIL ws_w16 cyc=%0d s=%0d: got %h/%h/%b want %h/%h/%b", cyc, b.s, w16_out_data, w16_out_keep, w16_out_err, ed[127:0], ek[15:0], m_err(b.s, 16)); end
                    n_tests++;
                    ed = m_data(b.d, b.s, 64); ek = m_keep(b.k, b.s, 64);
                    if (w64_out_data !== ed || w64_out_keep !== ek || w64_out_last !== b.l || w64_out_err !== m_err(b.s, 64)) begin
                        n_fail++; $display("FAIL ws_w64 cyc=%0d s=%0d: got keep %h err %b want keep %h err %b", cyc, b.s, w64_out_keep, w64_out_err, ek, m_err(b.s, 64)); end
                end
            end
            if (w_in_valid && w2_in_ready === 1'b1) begin
                b.d = w_data; b.k = w_keep; b.l = w_last; b.s = int'(w_size);
                q.push_back(b);
                if (m_err(b.s, 2))  ec2++;
                if (m_err(b.s, 16)) ec16++;
                if (m_err(b.s, 64)) ec64++;
            end
            tick();
        end
        w_in_valid = 1'b0; w_out_ready = 1'b0;
        n_tests++; if (q.size() != 0 || w2_out_valid !== 1'b0) begin n_fail++; $display("FAIL ws_drain: got %0d pending v=%b want 0 pending v=0", q.size(), w2_out_valid); end
        n_tests++; if (w2_err !== 16'(ec2) || w16_err !== 16'(ec16) || w64_err !== 16'(ec64)) begin
            n_fail++; $display("FAIL ws_err_count: got %0d/%0d/%0d want %0d/%0d/%0d", w2_err, w16_err, w64_err, ec2, ec16, ec64); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_keep = '0; a_in_last = 1'b0; a_size = '0; a_out_ready = 1'b0;
        w_in_valid = 1'b0; w_data = '0; w_keep = '0; w_last = 1'b0; w_size = '0; w_out_ready = 1'b0;
        test_reset();
        test_size_sweep();
        test_stream();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_width_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
